led_fade_driver: RTL and testbench
==================================

Name: led_fade_driver

Overview:
- Downstream stage of the memory-mapped LED register; consumes its 8-bit LED value and drives the board LED pins.
- Each LED ramps its brightness up to full when its bit is set and down to off when cleared.
- Brightness is rendered as glitch-free PWM, so software writes produce smooth fades instead of hard on/off edges.

Parameters:
NUM_LEDS, 8, number of LED channels (width of leds_val and leds_out)
PWM_BITS, 8, width of PWM counter and per-LED level; MAX = 2^PWM_BITS-1
STEP_DIV, 1024, clocks per fade step (>=2); full fade takes MAX*STEP_DIV enabled clocks

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
leds_val  input  NUM_LEDS  target pattern from the LED register; bit=1 means fade to full, bit=0 means fade to off
enable  input  1  1 = run counters and drive LEDs; 0 = freeze state, LEDs dark
leds_out  output  NUM_LEDS  registered LED pin drive, active-high
fade_busy  output  1  registered; 1 while any level differs from its target

Behaviour:
- Reset: one clock, asynchronous, active-low (reset_n). Asserting it immediately clears pwm_cnt, step_cnt, every level, every duty, leds_out=0 and fade_busy=0. This holds mid-fade. After release, state resumes from zero.
- pwm_cnt (PWM_BITS): +1 per clock while enable=1; wraps MAX->0.
- step_cnt: counts 0..STEP_DIV-1 while enable=1.
  - step_tick = enable && step_cnt==STEP_DIV-1; step_cnt wraps to 0 on that cycle.
- level[i] (PWM_BITS), updated only on step_tick:
  - leds_val[i]=1 and level<MAX: +1.
  - leds_val[i]=0 and level>0: -1.
  - Otherwise hold (saturating at both ends).
  - leds_val is sampled only on step_tick. A toggle between ticks reverses direction at the next tick, with no jump.
- duty[i] (PWM_BITS): loaded from level[i] (or from its gamma value, see Optional Feature) only on the cycle where enable && pwm_cnt==MAX. A level change never alters the current PWM period.
- leds_out[i], registered:
  - enable=0: 0.
  - duty==MAX: 1 (constant on).
  - Otherwise: (duty[i] > pwm_cnt).
  - Result: duty d gives d high cycles of every 2^PWM_BITS, with the high phase starting at pwm_cnt=0. The output lags the counter compare by 1 clock.
- fade_busy: registered OR over i of (level[i] != (leds_val[i] ? MAX : 0)), using current leds_val and level. It therefore reflects a change 1 clock later.
- enable=0:
  - pwm_cnt, step_cnt, level and duty hold.
  - leds_out goes to 0 on the next clock.
  - fade_busy keeps updating from leds_val.
  - On re-enable, counting resumes from the held values with no extra step.
- Simultaneous events: a step_tick and a duty load in the same cycle are legal. duty takes the pre-tick level; the new level appears in the following period.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: duty load value = (level*level) >> PWM_BITS. Use a 2*PWM_BITS-wide product, upper PWM_BITS kept, with level==MAX forced to MAX. This gives perceptually linear fades.
- Undefined: duty load value = level. No multiplier is instantiated.

Test Plan (PWM_BITS=4, STEP_DIV=4, NUM_LEDS=8 unless noted):
- Ramp up: after reset, leds_val=0x01, enable=1 -> fade_busy=1 from the 2nd clock. level[0] reaches 15 after 60 clocks and fade_busy drops 1 clock later. From the next PWM period on, leds_out[0]=1 constantly. leds_out[7:1]=0 throughout.
- Reverse mid-fade: set leds_val=0x01, then leds_val=0x00 when level[0]=8 -> level decrements once per 4 clocks, reaching 0 after 32 clocks. At duty 8, leds_out[0] is high for pwm_cnt 0..7 (+1 clk lag) and low for 8..15.
- Period boundary: level changes 5->6 while pwm_cnt=3 -> the current period still shows 5 high cycles; the next period (after pwm_cnt 15->0) shows 6.
- Freeze: enable=0 for 20 clocks during a fade -> leds_out=0 from the next clock, level/pwm_cnt/step_cnt unchanged. After enable=1, the remaining fade takes exactly the original remaining clock count.
- Async reset: pull reset_n low mid-period with leds_out=0xFF -> leds_out=0x00 and fade_busy=0 without waiting for a clk edge. After release with leds_val=0xFF, all channels restart from level 0.
- Gamma: with LED_FADE_GAMMA_EN and level held at 8 -> duty=4, so 4 of 16 cycles are high. Without the macro -> 8 of 16 cycles high. At level 15, both builds give constant high.

Source files
------------

// File: rtl/led_fade_driver.sv
// LED fade driver: per-channel brightness ramps toward the leds_val target
// and is rendered as period-aligned PWM on leds_out.
// Optional macro LED_FADE_GAMMA_EN: square-law duty mapping for perceptually
// linear fades; when undefined the duty is the raw level and no multiplier exists.
module led_fade_driver #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] leds_val,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] leds_out,
  output logic                fade_busy
);

  localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned PROD_W = 2 * PWM_BITS;
  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt, pwm_cnt_nxt;
  logic [STEP_W-1:0]   step_cnt, step_cnt_nxt;
  logic [PWM_BITS-1:0] level     [NUM_LEDS];
  logic [PWM_BITS-1:0] level_nxt [NUM_LEDS];
  logic [PWM_BITS-1:0] duty      [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_nxt  [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_load [NUM_LEDS];
  logic [NUM_LEDS-1:0] leds_out_nxt;
  logic                busy_nxt;
  logic                step_tick;
  logic                pwm_wrap;

  assign step_tick = enable && (step_cnt == STEP_LAST);
  assign pwm_wrap  = enable && (pwm_cnt == LVL_MAX);

`ifdef LED_FADE_GAMMA_EN
  logic [PROD_W-1:0] sq [NUM_LEDS];

  // Square-law duty: upper half of level*level, full level pinned to full duty
  always_comb begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      sq[i]        = PROD_W'(level[i]) * PROD_W'(level[i]);
      duty_load[i] = (level[i] == LVL_MAX) ? LVL_MAX : PWM_BITS'(sq[i] >> PWM_BITS);
    end
  end
`else
  // Linear duty: the level itself
  always_comb begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      duty_load[i] = level[i];
    end
  end
`endif

  // PWM and fade-step counters advance only while enabled
  always_comb begin
    pwm_cnt_nxt  = pwm_cnt;
    step_cnt_nxt = step_cnt;
    if (enable) begin
      pwm_cnt_nxt  = pwm_cnt + 1'b1;
      step_cnt_nxt = step_tick ? '0 : step_cnt + 1'b1;
    end
  end

  // Saturating level ramp on step ticks; duty latched from the pre-tick level at period end
  always_comb begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      level_nxt[i] = level[i];
      duty_nxt[i]  = duty[i];
      if (step_tick) begin
        if (leds_val[i] && (level[i] != LVL_MAX)) begin
          level_nxt[i] = level[i] + 1'b1;
        end else if (!leds_val[i] && (level[i] != '0)) begin
          level_nxt[i] = level[i] - 1'b1;
        end
      end
      if (pwm_wrap) begin
        duty_nxt[i] = duty_load[i];
      end
    end
  end

  // PWM compare and busy detection, both registered below
  always_comb begin
    leds_out_nxt = '0;
    busy_nxt     = 1'b0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (enable) begin
        leds_out_nxt[i] = (duty[i] == LVL_MAX) || (duty[i] > pwm_cnt);
      end
      if (level[i] != (leds_val[i] ? LVL_MAX : {PWM_BITS{1'b0}})) begin
        busy_nxt = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt   <= '0;
      step_cnt  <= '0;
      leds_out  <= '0;
      fade_busy <= 1'b0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        level[i] <= '0;
        duty[i]  <= '0;
      end
    end else begin
      pwm_cnt   <= pwm_cnt_nxt;
      step_cnt  <= step_cnt_nxt;
      leds_out  <= leds_out_nxt;
      fade_busy <= busy_nxt;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        level[i] <= level_nxt[i];
        duty[i]  <= duty_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver (PWM_BITS=4, STEP_DIV=4, NUM_LEDS=8).
// Per-cycle expectations come from a behavioural model through a scoreboard
// queue; directed checks cover ramp timing, per-period high counts, freeze
// and asynchronous reset.
module tb_led_fade_driver;

  localparam int NL = 8;
  localparam int PB = 4;
  localparam int SD = 4;
  localparam int MX = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NL-1:0] leds_val = '0;
  logic          enable = 1'b0;
  logic [NL-1:0] leds_out;
  logic          fade_busy;

  led_fade_driver #(.NUM_LEDS(NL), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .leds_val  (leds_val),
    .enable    (enable),
    .leds_out  (leds_out),
    .fade_busy (fade_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NL-1:0] out;
    logic          busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_pwm, m_step;
  int   m_level[NL];
  int   m_duty[NL];
  int   cyc;
  int   last_busy_cyc;

  function automatic int gamma(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l == MX) ? MX : ((l * l) >> PB);
`else
    return l;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pwm = 0;
    m_step = 0;
    for (int i = 0; i < NL; i++) begin
      m_level[i] = 0;
      m_duty[i]  = 0;
    end
    cyc = 0;
    last_busy_cyc = 0;
    sb.delete();
  endtask

  // One clock: drive inputs, push model expectation, compare after the edge
  task automatic cycle(input logic en, input logic [NL-1:0] val);
    exp_t e;
    bit   tick;
    enable   = en;
    leds_val = val;
    e.out  = '0;
    e.busy = 1'b0;
    for (int i = 0; i < NL; i++) begin
      e.out[i] = en && ((m_duty[i] == MX) || (m_duty[i] > m_pwm));
      if (m_level[i] != (val[i] ? MX : 0)) e.busy = 1'b1;
    end
    sb.push_back(e);
    if (en) begin
      tick = (m_step == SD - 1);
      if (m_pwm == MX) begin
        for (int i = 0; i < NL; i++) m_duty[i] = gamma(m_level[i]);
      end
      if (tick) begin
        for (int i = 0; i < NL; i++) begin
          if (val[i] && m_level[i] < MX) m_level[i]++;
          else if (!val[i] && m_level[i] > 0) m_level[i]--;
        end
      end
      m_pwm  = (m_pwm + 1) % (MX + 1);
      m_step = tick ? 0 : m_step + 1;
    end
    @(posedge clk);
    #1;
    if (en) cyc++;
    e = sb.pop_front();
    check("leds_out", 32'(leds_out), 32'(e.out));
    check("fade_busy", 32'(fade_busy), 32'(e.busy));
    if (fade_busy) last_busy_cyc = cyc;
  endtask

  task automatic period_highs(input logic [NL-1:0] val, output int hi);
    hi = 0;
    repeat (MX + 1) begin
      cycle(1'b1, val);
      hi += int'(leds_out[0]);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check("rst_out", 32'(leds_out), 32'h0);
    check("rst_busy", 32'(fade_busy), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_out", 32'(leds_out), 32'h0);
    model_reset();
    reset_n = 1'b1;
  endtask

  int hi;

  initial begin
    #2;
    do_reset();

    // Ramp up channel 0; loads at enabled clocks 16,32,48,64 take levels 3,7,11,15
    repeat (16) begin
      cycle(1'b1, 8'h01);
      if (cyc == 1) check("busy_after_1st", 32'(fade_busy), 32'h1);
    end
    period_highs(8'h01, hi); check("ramp_p1_highs", 32'(hi), 32'(gamma(3)));
    period_highs(8'h01, hi); check("ramp_p2_highs", 32'(hi), 32'(gamma(7)));
    period_highs(8'h01, hi); check("ramp_p3_highs", 32'(hi), 32'(gamma(11)));
    period_highs(8'h01, hi); check("ramp_full_highs", 32'(hi), 32'(MX + 1));
    check("ramp_busy_end", 32'(last_busy_cyc), 32'd60);
    check("ramp_upper_dark", 32'(leds_out[7:1]), 32'h0);

    // Reverse at level 8: loads at 48 and 64 take levels 5 and 1
    do_reset();
    repeat (32) cycle(1'b1, 8'h01);
    repeat (16) cycle(1'b1, 8'h00);
    period_highs(8'h00, hi); check("rev_p1_highs", 32'(hi), 32'(gamma(5)));
    period_highs(8'h00, hi); check("rev_p2_highs", 32'(hi), 32'(gamma(1)));
    check("rev_busy_end", 32'(last_busy_cyc), 32'd64);

    // Freeze 20 clocks mid-fade; remaining fade length is unchanged
    do_reset();
    cycle(1'b0, 8'h00);
    check("frz_idle_busy", 32'(fade_busy), 32'h0);
    cycle(1'b0, 8'h01);
    check("frz_busy_tracks_val", 32'(fade_busy), 32'h1);
    repeat (30) cycle(1'b1, 8'h01);
    repeat (20) begin
      cycle(1'b0, 8'h01);
      check("frz_dark", 32'(leds_out), 32'h0);
    end
    repeat (60) cycle(1'b1, 8'h01);
    check("frz_busy_end", 32'(last_busy_cyc), 32'd60);
    check("frz_full_on", 32'(leds_out), 32'h01);

    // Asynchronous reset with all LEDs lit, then full restart
    do_reset();
    repeat (80) cycle(1'b1, 8'hFF);
    check("async_pre_on", 32'(leds_out), 32'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_out", 32'(leds_out), 32'h0);
    check("async_busy", 32'(fade_busy), 32'h0);
    #1;
    model_reset();
    reset_n = 1'b1;
    repeat (16) cycle(1'b1, 8'hFF);
    period_highs(8'hFF, hi); check("async_restart_highs", 32'(hi), 32'(gamma(3)));
    repeat (48) cycle(1'b1, 8'hFF);
    check("async_busy_end", 32'(last_busy_cyc), 32'd60);
    check("async_full_on", 32'(leds_out), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
